// File: rtl/m_axi_rd_master_if.sv
// AXI read-address and read-data channels between a single-outstanding
// read master and its responder.
interface m_axi_rd_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic              m_axi_rvalid;
    logic              m_axi_rready;
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;

    modport master (
        output m_axi_arvalid, m_axi_araddr, m_axi_rready,
        input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp
    );

    modport slave (
        input  m_axi_arvalid, m_axi_araddr, m_axi_rready,
        output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp
    );
endinterface

// File: rtl/m_axi_rd_master.sv
// Single-outstanding AXI read master: one command -> one AR/R transaction,
// with saturating read/error counters and a sticky per-transaction watchdog.
module m_axi_rd_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              m_axi_aclk,
    input  logic              m_axi_aresetn,
    m_axi_rd_master_if.master axi,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_resp,
    output logic [15:0]       rd_count,
    output logic [15:0]       err_count,
    output logic              timeout_flag
);
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);
    localparam logic [15:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic [15:0]       rd_cnt_q, rd_cnt_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [15:0]       wd_q, wd_d;
    logic              tof_q, tof_d;

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q     <= IDLE;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= '0;
            rd_cnt_q    <= '0;
            err_cnt_q   <= '0;
            wd_q        <= '0;
            tof_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
            rd_cnt_q    <= rd_cnt_d;
            err_cnt_q   <= err_cnt_d;
            wd_q        <= wd_d;
            tof_q       <= tof_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;
        rd_cnt_d    = rd_cnt_q;
        err_cnt_d   = err_cnt_q;
        wd_d        = wd_q;
        tof_d       = tof_q;

        // Watchdog saturates at the limit; the flag only alerts, the FSM keeps waiting.
        if (state_q != IDLE) begin
            if (wd_q != WD_LIMIT) wd_d = wd_q + 16'd1;
            if (wd_d == WD_LIMIT) tof_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    araddr_d  = cmd_addr;
                    arvalid_d = 1'b1;
                    tof_d     = 1'b0;
                    wd_d      = '0;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (axi.m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (axi.m_axi_rvalid) begin
                    rsp_data_d  = axi.m_axi_rdata;
                    rsp_resp_d  = axi.m_axi_rresp;
                    rsp_valid_d = 1'b1;
                    rready_d    = 1'b0;
                    if (rd_cnt_q != CNT_MAX) rd_cnt_d = rd_cnt_q + 16'd1;
                    if (axi.m_axi_rresp[1] && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready         = (state_q == IDLE);
    assign axi.m_axi_arvalid = arvalid_q;
    assign axi.m_axi_araddr  = araddr_q;
    assign axi.m_axi_rready  = rready_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_data          = rsp_data_q;
    assign rsp_resp          = rsp_resp_q;
    assign rd_count          = rd_cnt_q;
    assign err_count         = err_cnt_q;
    assign timeout_flag      = tof_q;
endmodule

// File: tb/tb_m_axi_rd_master.sv
// Directed bench for m_axi_rd_master: a negedge-driven responder returns
// data = addr*5 with programmable AR wait, response code and R suppression.
module tb_m_axi_rd_master;
    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [15:0] rd_count;
    logic [15:0] err_count;
    logic        timeout_flag;

    int unsigned n_checks;
    int unsigned n_fails;

    int unsigned ar_delay;
    int unsigned ar_cnt;
    logic        r_en;
    logic        early_r;
    logic [1:0]  resp_code;
    logic [31:0] ar_lat;

    m_axi_rd_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    m_axi_rd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .m_axi_aclk   (clk),
        .m_axi_aresetn(rst_n),
        .axi          (axi),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_resp     (rsp_resp),
        .rd_count     (rd_count),
        .err_count    (err_count),
        .timeout_flag (timeout_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Responder: decides arready/rvalid at the negedge for the following posedge.
    always @(negedge clk) begin
        axi.m_axi_arready = 1'b0;
        axi.m_axi_rvalid  = 1'b0;
        axi.m_axi_rdata   = '0;
        axi.m_axi_rresp   = '0;
        if (!rst_n) begin
            ar_cnt = 0;
        end else begin
            if (axi.m_axi_arvalid) begin
                if (ar_cnt >= ar_delay) begin
                    axi.m_axi_arready = 1'b1;
                    ar_lat            = axi.m_axi_araddr;
                    ar_cnt            = 0;
                end else begin
                    ar_cnt++;
                end
            end
            if (r_en && (axi.m_axi_rready || early_r)) begin
                axi.m_axi_rvalid = 1'b1;
                axi.m_axi_rdata  = ar_lat * 32'd5;
                axi.m_axi_rresp  = resp_code;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        r_en      = 1'b1;
        early_r   = 1'b0;
        ar_delay  = 0;
        resp_code = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fails++; $display("FAIL reset_cmd_ready: got %0h want 1", cmd_ready); end
        n_checks++; if (axi.m_axi_arvalid !== 1'b0) begin n_fails++; $display("FAIL reset_arvalid: got %0h want 0", axi.m_axi_arvalid); end
        n_checks++; if (axi.m_axi_rready !== 1'b0) begin n_fails++; $display("FAIL reset_rready: got %0h want 0", axi.m_axi_rready); end
        n_checks++; if (axi.m_axi_araddr !== 32'd0) begin n_fails++; $display("FAIL reset_araddr: got %0h want 0", axi.m_axi_araddr); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fails++; $display("FAIL reset_rsp_valid: got %0h want 0", rsp_valid); end
        n_checks++; if ({rsp_data, rsp_resp} !== 34'd0) begin n_fails++; $display("FAIL reset_rsp: got %0h want 0", {rsp_data, rsp_resp}); end
        n_checks++; if ({rd_count, err_count} !== 32'd0) begin n_fails++; $display("FAIL reset_counts: got %0h want 0", {rd_count, err_count}); end
        n_checks++; if (timeout_flag !== 1'b0) begin n_fails++; $display("FAIL reset_timeout: got %0h want 0", timeout_flag); end
    endtask

    task automatic test_basic_read();
        do_reset();
        @(negedge clk); cmd_valid = 1'b1; cmd_addr = 32'd3;
        @(negedge clk); cmd_valid = 1'b0;
        n_checks++; if (axi.m_axi_arvalid !== 1'b1 || axi.m_axi_araddr !== 32'd3) begin n_fails++; $display("FAIL basic_ar_c1: got v=%0h a=%0h want v=1 a=3", axi.m_axi_arvalid, axi.m_axi_araddr); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fails++; $display("FAIL basic_cmd_ready_c1: got %0h want 0", cmd_ready); end
        @(negedge clk);
        n_checks++; if (axi.m_axi_rready !== 1'b1 || axi.m_axi_arvalid !== 1'b0) begin n_fails++; $display("FAIL basic_r_c2: got rready=%0h arvalid=%0h want 1/0", axi.m_axi_rready, axi.m_axi_arvalid); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1) begin n_fails++; $display("FAIL basic_rsp_valid_c3: got %0h want 1", rsp_valid); end
        n_checks++; if (rsp_data !== 32'd15 || rsp_resp !== 2'b00) begin n_fails++; $display("FAIL basic_rsp_c3: got d=%0d r=%0h want d=15 r=0", rsp_data, rsp_resp); end
        n_checks++; if (rd_count !== 16'd1 || err_count !== 16'd0) begin n_fails++; $display("FAIL basic_counts: got rd=%0d err=%0d want 1/0", rd_count, err_count); end
        n_checks++; if (cmd_ready !== 1'b1 || axi.m_axi_rready !== 1'b0) begin n_fails++; $display("FAIL basic_idle_c3: got cmd_ready=%0h rready=%0h want 1/0", cmd_ready, axi.m_axi_rready); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd15) begin n_fails++; $display("FAIL basic_hold_c4: got v=%0h d=%0d want 0/15", rsp_valid, rsp_data); end
    endtask

    // arready held low 5 cycles; cmd_valid stays high with a different address and
    // rvalid is offered early -- both must be ignored until the AR handshake.
    task automatic test_ar_wait();
        do_reset();
        ar_delay = 5;
        early_r  = 1'b1;
        @(negedge clk); cmd_valid = 1'b1; cmd_addr = 32'd7;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) cmd_addr = 32'd99;
            if (k == 6) cmd_valid = 1'b0;
            n_checks++; if (axi.m_axi_arvalid !== 1'b1 || axi.m_axi_araddr !== 32'd7) begin n_fails++; $display("FAIL arwait_hold_c%0d: got v=%0h a=%0d want 1/7", k, axi.m_axi_arvalid, axi.m_axi_araddr); end
            n_checks++; if (rsp_valid !== 1'b0 || axi.m_axi_rready !== 1'b0) begin n_fails++; $display("FAIL arwait_early_r_c%0d: got rsp_valid=%0h rready=%0h want 0/0", k, rsp_valid, axi.m_axi_rready); end
        end
        @(negedge clk);
        n_checks++; if (axi.m_axi_rready !== 1'b1 || axi.m_axi_arvalid !== 1'b0) begin n_fails++; $display("FAIL arwait_data_c7: got rready=%0h arvalid=%0h want 1/0", axi.m_axi_rready, axi.m_axi_arvalid); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd35) begin n_fails++; $display("FAIL arwait_rsp_c8: got v=%0h d=%0d want 1/35", rsp_valid, rsp_data); end
        n_checks++; if (rd_count !== 16'd1) begin n_fails++; $display("FAIL arwait_rd_count: got %0d want 1", rd_count); end
        n_checks++; if (timeout_flag !== 1'b0) begin n_fails++; $display("FAIL arwait_no_timeout_7cyc: got %0h want 0", timeout_flag); end
        early_r = 1'b0;
        ar_delay = 0;
    endtask

    task automatic test_err_resp();
        do_reset();
        resp_code = 2'b11;
        @(negedge clk); cmd_valid = 1'b1; cmd_addr = 32'd20;
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b11 || rsp_data !== 32'd100) begin n_fails++; $display("FAIL err11_rsp: got v=%0h r=%0h d=%0d want 1/3/100", rsp_valid, rsp_resp, rsp_data); end
        n_checks++; if (err_count !== 16'd1 || rd_count !== 16'd1) begin n_fails++; $display("FAIL err11_counts: got err=%0d rd=%0d want 1/1", err_count, rd_count); end
        resp_code = 2'b10;
        cmd_valid = 1'b1; cmd_addr = 32'd1;
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (rsp_resp !== 2'b10 || err_count !== 16'd2 || rd_count !== 16'd2) begin n_fails++; $display("FAIL err10: got r=%0h err=%0d rd=%0d want 2/2/2", rsp_resp, err_count, rd_count); end
        resp_code = 2'b01;
        cmd_valid = 1'b1; cmd_addr = 32'd2;
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (rsp_resp !== 2'b01 || err_count !== 16'd2 || rd_count !== 16'd3) begin n_fails++; $display("FAIL err01_not_error: got r=%0h err=%0d rd=%0d want 1/2/3", rsp_resp, err_count, rd_count); end
        resp_code = 2'b00;
    endtask

    task automatic test_timeout();
        do_reset();
        r_en = 1'b0;
        @(negedge clk); cmd_valid = 1'b1; cmd_addr = 32'd9;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
        end
        n_checks++; if (timeout_flag !== 1'b0) begin n_fails++; $display("FAIL timeout_early_7edges: got %0h want 0", timeout_flag); end
        @(negedge clk);
        n_checks++; if (timeout_flag !== 1'b1) begin n_fails++; $display("FAIL timeout_set_8edges: got %0h want 1", timeout_flag); end
        n_checks++; if (axi.m_axi_rready !== 1'b1 || cmd_ready !== 1'b0) begin n_fails++; $display("FAIL timeout_waiting: got rready=%0h cmd_ready=%0h want 1/0", axi.m_axi_rready, cmd_ready); end
        repeat (10) @(negedge clk);
        n_checks++; if (timeout_flag !== 1'b1 || axi.m_axi_rready !== 1'b1 || cmd_ready !== 1'b0) begin n_fails++; $display("FAIL timeout_sticky: got flag=%0h rready=%0h cmd_ready=%0h want 1/1/0", timeout_flag, axi.m_axi_rready, cmd_ready); end
        #2 r_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd45 || timeout_flag !== 1'b1) begin n_fails++; $display("FAIL timeout_late_rsp: got v=%0h d=%0d flag=%0h want 1/45/1", rsp_valid, rsp_data, timeout_flag); end
        cmd_valid = 1'b1; cmd_addr = 32'd2;
        @(negedge clk); cmd_valid = 1'b0;
        n_checks++; if (timeout_flag !== 1'b0 || axi.m_axi_arvalid !== 1'b1) begin n_fails++; $display("FAIL timeout_clear_on_accept: got flag=%0h arvalid=%0h want 0/1", timeout_flag, axi.m_axi_arvalid); end
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (rsp_data !== 32'd10 || rd_count !== 16'd2) begin n_fails++; $display("FAIL timeout_next_read: got d=%0d rd=%0d want 10/2", rsp_data, rd_count); end
    endtask

    task automatic test_reset_mid_txn();
        do_reset();
        @(negedge clk); cmd_valid = 1'b1; cmd_addr = 32'd3;
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        r_en = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 32'd4;
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (axi.m_axi_rready !== 1'b1 || rd_count !== 16'd1 || rsp_data !== 32'd15) begin n_fails++; $display("FAIL midrst_pre: got rready=%0h rd=%0d d=%0d want 1/1/15", axi.m_axi_rready, rd_count, rsp_data); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (axi.m_axi_rready !== 1'b0 || axi.m_axi_arvalid !== 1'b0 || axi.m_axi_araddr !== 32'd0) begin n_fails++; $display("FAIL midrst_axi: got rready=%0h arvalid=%0h araddr=%0h want 0/0/0", axi.m_axi_rready, axi.m_axi_arvalid, axi.m_axi_araddr); end
        n_checks++; if (rsp_data !== 32'd0 || rd_count !== 16'd0 || cmd_ready !== 1'b1 || timeout_flag !== 1'b0) begin n_fails++; $display("FAIL midrst_regs: got d=%0d rd=%0d cmd_ready=%0h flag=%0h want 0/0/1/0", rsp_data, rd_count, cmd_ready, timeout_flag); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fails++; $display("FAIL midrst_no_rsp: got %0h want 0", rsp_valid); end
        rst_n = 1'b1;
        r_en  = 1'b1;
        @(negedge clk); cmd_valid = 1'b1; cmd_addr = 32'd0;
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rd_count !== 16'd1) begin n_fails++; $display("FAIL midrst_after: got v=%0h d=%0d rd=%0d want 1/0/1", rsp_valid, rsp_data, rd_count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d;
        do_reset();
        @(negedge clk); cmd_valid = 1'b1; cmd_addr = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (axi.m_axi_arvalid !== 1'b1 || axi.m_axi_araddr !== 32'(i)) begin n_fails++; $display("FAIL b2b_ar_%0d: got v=%0h a=%0d want 1/%0d", i, axi.m_axi_arvalid, axi.m_axi_araddr, i); end
            if (i < 3) cmd_addr = 32'(i + 1);
            else       cmd_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            exp_d = 32'(i * 5);
            n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rd_count !== 16'(i + 1) || cmd_ready !== 1'b1) begin n_fails++; $display("FAIL b2b_rsp_%0d: got v=%0h d=%0d rd=%0d cr=%0h want 1/%0d/%0d/1", i, rsp_valid, rsp_data, rd_count, cmd_ready, exp_d, i + 1); end
        end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || axi.m_axi_arvalid !== 1'b0 || rd_count !== 16'd4) begin n_fails++; $display("FAIL b2b_end: got v=%0h cr=%0h arvalid=%0h rd=%0d want 0/1/0/4", rsp_valid, cmd_ready, axi.m_axi_arvalid, rd_count); end
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        r_en      = 1'b1;
        early_r   = 1'b0;
        ar_delay  = 0;
        resp_code = 2'b00;
        ar_lat    = '0;
        test_reset();
        test_basic_read();
        test_ar_wait();
        test_err_resp();
        test_timeout();
        test_reset_mid_txn();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/m_axi_rd_master.md
M_AXI_RD_MASTER -- requirements
Module: m_axi_rd_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI read-address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI read-data width.
REQ-003 SHALL have parameter TIMEOUT, default 64, watchdog limit in cycles (range 2..65535).
REQ-004 SHALL have port m_axi_aclk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port m_axi_aresetn  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port cmd_valid  input  1  user requests one read.
REQ-007 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-008 SHALL have port cmd_addr  input  ADDR_W  read address for the command.
REQ-009 SHALL have port m_axi_arvalid  output  1  read-address valid.
REQ-010 SHALL have port m_axi_arready  input  1  read-address ready from responder.
REQ-011 SHALL have port m_axi_araddr  output  ADDR_W  read address.
REQ-012 SHALL have port m_axi_rvalid  input  1  read-data valid from responder.
REQ-013 SHALL have port m_axi_rready  output  1  master ready for read data.
REQ-014 SHALL have port m_axi_rdata  input  DATA_W  read data.
REQ-015 SHALL have port m_axi_rresp  input  2  read response.
REQ-016 SHALL have port rsp_valid  output  1  one-cycle pulse: result available.
REQ-017 SHALL have port rsp_data  output  DATA_W  captured read data.
REQ-018 SHALL have port rsp_resp  output  2  captured response code.
REQ-019 SHALL have port rd_count  output  16  completed reads, saturating.
REQ-020 SHALL have port err_count  output  16  completed reads with rresp[1]=1, saturating.
REQ-021 SHALL have port timeout_flag  output  1  sticky watchdog expiry indicator.

Function
REQ-022 SHALL implement FSM states IDLE, ADDR, DATA; only one transaction outstanding.
REQ-023 SHALL drive cmd_ready = 1 exactly when state is IDLE (combinational from state).
REQ-024 IDLE: on cmd_valid=1, SHALL latch cmd_addr into m_axi_araddr, set m_axi_arvalid=1, clear timeout_flag, go to ADDR next cycle.
REQ-025 ADDR: SHALL hold m_axi_arvalid=1 and m_axi_araddr stable until the cycle m_axi_arready=1 is sampled; no abort or address change allowed.
REQ-026 On ADDR handshake SHALL clear m_axi_arvalid, set m_axi_rready=1, go to DATA.
REQ-027 DATA: SHALL hold m_axi_rready=1; m_axi_rvalid arriving before the AR handshake is ignored.
REQ-028 On R handshake SHALL register m_axi_rdata/m_axi_rresp into rsp_data/rsp_resp, pulse rsp_valid for exactly one cycle, clear m_axi_rready, return to IDLE.
REQ-029 Minimum latency: cmd accept (cycle 0) -> arvalid high cycle 1 -> rready high cycle 2 if arready=1 in cycle 1 -> rsp_valid cycle 3 if rvalid=1 in cycle 2; next cmd accepted in cycle 3.
REQ-030 rsp_data/rsp_resp SHALL hold the last captured value until the next R handshake.
REQ-031 rd_count SHALL increment by 1 per R handshake, holding at 0xFFFF.
REQ-032 err_count SHALL increment by 1 per R handshake with rresp = 2'b10 or 2'b11, holding at 0xFFFF.
REQ-033 Watchdog SHALL count cycles spent in ADDR+DATA per transaction; when it reaches TIMEOUT, timeout_flag SHALL set and stay set; the FSM SHALL keep waiting (no protocol violation).
REQ-034 Watchdog counter SHALL reset to 0 on each cmd accept and SHALL not wrap.
REQ-035 cmd_valid while not IDLE SHALL be ignored (no latch, no state change).

Reset
REQ-036 On m_axi_aresetn=0, immediately and independent of clock: state IDLE, m_axi_arvalid=0, m_axi_rready=0, m_axi_araddr=0, rsp_valid=0, rsp_data=0, rsp_resp=0, rd_count=0, err_count=0, timeout_flag=0, watchdog=0.
REQ-037 Reset asserted mid-transaction SHALL abandon it without a rsp_valid pulse; first accept possible on the first rising edge after deassertion.

Verification
REQ-038 Responder returns data=addr*5, resp 00, zero wait: cmd_addr=3 -> rsp_valid at cycle 3, rsp_data=15, rsp_resp=00, rd_count=1.
REQ-039 Responder holds arready=0 for 5 cycles: araddr stays 7 and arvalid stays 1 throughout; rsp_data=35 after handshake.
REQ-040 cmd_addr=20, responder returns resp 11: rsp_resp=11, err_count=1, rd_count=1.
REQ-041 TIMEOUT=8, responder never asserts rvalid: timeout_flag=1 at 8th cycle after accept, rready stays 1, cmd_ready stays 0; next successful command clears flag on accept.
REQ-042 Assert m_axi_aresetn=0 in DATA state mid-clock: all outputs zero before next edge, no rsp_valid; after release cmd_addr=0 reads 0 normally.
REQ-043 Back-to-back 4 reads (addr 0..3), cmd_valid held high: each accepted in the rsp_valid cycle of the previous; rd_count=4, data 0,5,10,15.
